// File: rtl/ysyx_24100006_idu_sched.sv
// Decode-stage scheduler: opcode classify, immediate extend,
// and a two-entry skid buffer between IF and EX.
module ysyx_24100006_imm_sext (
  input  logic [31:7] inst_i,
  input  logic [2:0]  type_i,
  output logic [31:0] imm_o
);

  always_comb begin
    imm_o = 32'h0;
    case (type_i)
      3'b000: imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
      3'b001: imm_o = {{11{inst_i[31]}}, inst_i[31],
                       inst_i[19:12], inst_i[20],
                       inst_i[30:21], 1'b0};
      3'b010: imm_o = {{20{inst_i[31]}}, inst_i[31:25],
                       inst_i[11:7]};
      3'b011: imm_o = {{19{inst_i[31]}}, inst_i[31],
                       inst_i[7], inst_i[30:25],
                       inst_i[11:8], 1'b0};
      3'b100: imm_o = {inst_i[31:12], 12'h0};
      default: imm_o = 32'h0;
    endcase
  end

endmodule

module ysyx_24100006_idu_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_imm,
  output logic [2:0]  out_imm_type,
  output logic        out_illegal,
  output logic [31:0] stall_cnt
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  localparam int PW = 100;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] skid_q, skid_d;
  logic [31:0]   stall_q, stall_d;

  logic [2:0]    dec_type;
  logic          dec_ill;
  logic [31:0]   dec_imm;
  logic [PW-1:0] new_pl;
  logic          accept, pop;

  always_comb begin
    dec_type = 3'b000;
    dec_ill  = 1'b0;
    case (in_inst[6:0])
      7'b0010011,
      7'b0000011,
      7'b1100111,
      7'b1110011: dec_type = 3'b000;
      7'b1101111: dec_type = 3'b001;
      7'b0100011: dec_type = 3'b010;
      7'b1100011: dec_type = 3'b011;
      7'b0110111,
      7'b0010111: dec_type = 3'b100;
      7'b0110011: dec_type = 3'b000;
      default:    dec_ill  = 1'b1;
    endcase
  end

  ysyx_24100006_imm_sext u_sext (
    .inst_i (in_inst[31:7]),
    .type_i (dec_type),
    .imm_o  (dec_imm)
  );

  assign new_pl = {in_inst, in_pc, dec_imm,
                   dec_type, dec_ill};

  // ready comes from registered state only
  assign in_ready  = (state_q != S_TWO);
  assign out_valid = (state_q != S_EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            head_d  = new_pl;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (accept && pop) begin
            head_d = new_pl;
          end else if (accept) begin
            skid_d  = new_pl;
            state_d = S_TWO;
          end else if (pop) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (pop) begin
            head_d  = skid_q;
            state_d = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready
        && stall_q != 32'hFFFF_FFFF)
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

  assign out_inst     = head_q[99:68];
  assign out_pc       = head_q[67:36];
  assign out_imm      = head_q[35:4];
  assign out_imm_type = head_q[3:1];
  assign out_illegal  = head_q[0];
  assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_ysyx_24100006_idu_sched.sv
// Directed bench for the decode-stage scheduler.
module tb_ysyx_24100006_idu_sched;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [2:0]  out_imm_type;
  logic        out_illegal;
  logic [31:0] stall_cnt;

  int checks;
  int errors;
  logic [31:0] exp_stall;

  ysyx_24100006_idu_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_inst      (in_inst),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_inst     (out_inst),
    .out_pc       (out_pc),
    .out_imm      (out_imm),
    .out_imm_type (out_imm_type),
    .out_illegal  (out_illegal),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_inst = '0; in_pc = '0;
    out_ready = 1'b0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", in_ready); end
    checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL rst_inst got %h exp 0", out_inst); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", out_pc); end
    checks++; if (out_imm !== 32'h0) begin errors++; $display("FAIL rst_imm got %h exp 0", out_imm); end
    checks++; if (out_imm_type !== 3'b000) begin errors++; $display("FAIL rst_type got %b exp 000", out_imm_type); end
    checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL rst_ill got %b exp 0", out_illegal); end
    checks++; if (stall_cnt !== 32'h0) begin errors++; $display("FAIL rst_stall got %h exp 0", stall_cnt); end
    #3 rst_n = 1'b1;
    exp_stall = 32'h0;
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc = 32'h8000_0000;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
    checks++; if (out_imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL single_imm got %h exp ffffffff", out_imm); end
    checks++; if (out_imm_type !== 3'b000) begin errors++; $display("FAIL single_type got %b exp 000", out_imm_type); end
    checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL single_ill got %b exp 0", out_illegal); end
    checks++; if (out_pc !== 32'h8000_0000) begin errors++; $display("FAIL single_pc got %h exp 80000000", out_pc); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] insts [3];
    logic [31:0] imms  [3];
    logic [2:0]  types [3];
    insts[0] = 32'h12345037; imms[0] = 32'h12345000; types[0] = 3'b100;
    insts[1] = 32'h008000EF; imms[1] = 32'h00000008; types[1] = 3'b001;
    insts[2] = 32'hFE20AE23; imms[2] = 32'hFFFFFFFC; types[2] = 3'b010;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_inst = insts[i]; in_pc = 32'h100 + 32'(4 * i);
      step();
      checks++; if (out_valid !== 1'b1 || out_inst !== insts[i]) begin errors++; $display("FAIL b2b_inst%0d got %b/%h exp 1/%h", i, out_valid, out_inst, insts[i]); end
      checks++; if (out_imm !== imms[i]) begin errors++; $display("FAIL b2b_imm%0d got %h exp %h", i, out_imm, imms[i]); end
      checks++; if (out_imm_type !== types[i]) begin errors++; $display("FAIL b2b_type%0d got %b exp %b", i, out_imm_type, types[i]); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h002081B3; in_pc = 32'h200;
    step();
    checks++; if (out_inst !== 32'h002081B3 || out_illegal !== 1'b0) begin errors++; $display("FAIL bp_a got %h/%b exp 002081b3/0", out_inst, out_illegal); end
    in_inst = 32'h00000000; in_pc = 32'h204;
    step();
    exp_stall = exp_stall + 1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got %b exp 0", in_ready); end
    in_inst = 32'hFE20AE23; in_pc = 32'h208;
    step();
    exp_stall = exp_stall + 1;
    checks++; if (in_ready !== 1'b0 || out_inst !== 32'h002081B3) begin errors++; $display("FAIL bp_hold got %b/%h exp 0/002081b3", in_ready, out_inst); end
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL bp_stall2 got %0d exp %0d", stall_cnt, exp_stall); end
    step();
    exp_stall = exp_stall + 1;
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL bp_stall3 got %0d exp %0d", stall_cnt, exp_stall); end
    out_ready = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1 || out_inst !== 32'h00000000) begin errors++; $display("FAIL bp_pop1 got %b/%h exp 1/00000000", in_ready, out_inst); end
    checks++; if (out_illegal !== 1'b1 || out_imm_type !== 3'b000) begin errors++; $display("FAIL bp_ill got %b/%b exp 1/000", out_illegal, out_imm_type); end
    checks++; if (out_pc !== 32'h204) begin errors++; $display("FAIL bp_pc1 got %h exp 204", out_pc); end
    step();
    in_valid = 1'b0;
    checks++; if (out_inst !== 32'hFE20AE23 || out_pc !== 32'h208) begin errors++; $display("FAIL bp_pop2 got %h/%h exp fe20ae23/208", out_inst, out_pc); end
    step();
    checks++; if (out_valid !== 1'b0 || stall_cnt !== exp_stall) begin errors++; $display("FAIL bp_end got %b/%0d exp 0/%0d", out_valid, stall_cnt, exp_stall); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h300;
    step();
    in_inst = 32'h00200113; in_pc = 32'h304;
    step();
    exp_stall = exp_stall + 1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_two got %b exp 0", in_ready); end
    flush = 1'b1; out_ready = 1'b1;
    in_inst = 32'h00300193; in_pc = 32'h308;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL fl_empty got %b/%b exp 0/1", out_valid, in_ready); end
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL fl_stall got %0d exp %0d", stall_cnt, exp_stall); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_nocap got %b exp 0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h0000A023; in_pc = 32'h400;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_imm_type !== 3'b010) begin errors++; $display("FAIL ar_one got %b/%b exp 1/010", out_valid, out_imm_type); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL ar_valid got %b/%b exp 0/1", out_valid, in_ready); end
    checks++; if (out_inst !== 32'h0 || out_pc !== 32'h0 || out_imm !== 32'h0) begin errors++; $display("FAIL ar_pl got %h/%h/%h exp 0/0/0", out_inst, out_pc, out_imm); end
    checks++; if (out_imm_type !== 3'b000 || out_illegal !== 1'b0 || stall_cnt !== 32'h0) begin errors++; $display("FAIL ar_misc got %b/%b/%h exp 000/0/0", out_imm_type, out_illegal, stall_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_after got %b exp 0", out_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_stall = 32'h0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
